// File: rtl/vga_frame_scheduler_if.sv
// rtl/vga_frame_scheduler_if.sv - raster timing outputs and game-update handshake bundle
interface vga_frame_scheduler_if;
    logic       pix_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
    logic       upd_req;
    logic       upd_ack;
    logic [7:0] overrun_cnt;

    modport master (
        output pix_tick, hsync, vsync, video_on, pixel_x, pixel_y,
        output frame_start, upd_req, overrun_cnt,
        input  upd_ack
    );

    modport slave (
        input  pix_tick, hsync, vsync, video_on, pixel_x, pixel_y,
        input  frame_start, upd_req, overrun_cnt,
        output upd_ack
    );
endinterface

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - pixel-rate raster sequencer with vblank game-update scheduling
module vga_frame_scheduler #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_frame_scheduler_if.master  vga_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } upd_state_e;

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          advance;

    logic          pix_tick_q;
    logic          hsync_q;
    logic          vsync_q;
    logic          video_on_q;
    logic          frame_start_q;

    upd_state_e    state_q;
    logic          upd_req_q;
    logic [7:0]    overrun_q;

    logic          vis_d;
    logic          hsync_d;
    logic          vsync_d;
    logic          origin_d;
    logic          req_pos_d;

    always_comb begin
        advance = (div_q == DIV_LAST);
        div_d   = advance ? '0 : div_q + 1'b1;
        h_d     = h_q;
        v_d     = v_q;
        if (advance) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Decode from the next counter values so outputs leave the same edge as the counters.
    always_comb begin
        vis_d     = (h_d < H_VIS) && (v_d < V_VIS);
        hsync_d   = !((h_d >= HS_START) && (h_d < HS_END));
        vsync_d   = !((v_d >= VS_START) && (v_d < VS_END));
        origin_d  = (h_d == 10'd0) && (v_d == 10'd0);
        req_pos_d = (h_d == 10'd0) && (v_d == V_VIS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            pix_tick_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pix_tick_q    <= advance;
            frame_start_q <= advance && origin_d;
            if (advance) begin
                hsync_q    <= hsync_d;
                vsync_q    <= vsync_d;
                video_on_q <= vis_d;
            end
        end
    end

    // An ack arriving on the same edge as the frame wrap takes priority over the overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            upd_req_q <= 1'b0;
            overrun_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (advance && req_pos_d) begin
                        state_q   <= REQ;
                        upd_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (vga_o.upd_ack) begin
                        state_q   <= DONE;
                        upd_req_q <= 1'b0;
                    end else if (advance && origin_d) begin
                        state_q   <= IDLE;
                        upd_req_q <= 1'b0;
                        if (overrun_q != 8'hFF) begin
                            overrun_q <= overrun_q + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (advance && origin_d) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    upd_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign vga_o.pix_tick    = pix_tick_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.video_on    = video_on_q;
    assign vga_o.pixel_x     = h_q;
    assign vga_o.pixel_y     = v_q;
    assign vga_o.frame_start = frame_start_q;
    assign vga_o.upd_req     = upd_req_q;
    assign vga_o.overrun_cnt = overrun_q;

endmodule
